// File: rtl/traffic_sched_pkg.sv
// Shared types and constants for the PRBS traffic command scheduler.
// Holds the scheduler state encoding, the command opcodes, the LFSR
// widths/tap masks and the burst-length mapping helper.
package traffic_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_GEN   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int unsigned ADDR_LFSR_W = 32;
    localparam int unsigned AUX_LFSR_W  = 15;
    localparam int unsigned BL_W        = 6;

    // Right-shifting Galois masks: tap n maps to bit n-1.
    localparam logic [ADDR_LFSR_W-1:0] ADDR_LFSR_TAPS = 32'h8020_0003;
    localparam logic [AUX_LFSR_W-1:0]  AUX_LFSR_TAPS  = 15'h6000;

    // A zero burst length is not legal on the command port; promote it to 1.
    function automatic logic [BL_W-1:0] blen_from_lfsr(input logic [BL_W-1:0] raw);
        return (raw == '0) ? BL_W'(1) : raw;
    endfunction

endpackage

// File: rtl/sched_lfsr.sv
// Galois LFSR with seed load and step enable.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset (state clears to 0)
//   load_i         : load seed_i (an all-zero seed is replaced by 1)
//   seed_i         : seed value
//   step_i         : advance one step (load_i has priority)
//   next_c_o       : combinational value the register takes on a step
module sched_lfsr #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] next_c_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    assign next_c_o = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

    // Load or step; zero is a lock-up state so it is never loaded.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? WIDTH'(1) : seed_i;
        end else if (step_i) begin
            lfsr_d = next_c_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/traffic_cmd_sched.sv
// PRBS memory traffic command scheduler.
// Seeds three LFSRs (address, instruction, burst length), forms aligned,
// range-limited commands and issues num_cmds_i of them over valid/ready.
// Ports:
//   clk_i, rst_n_i   : clock, async active-low reset
//   start_i          : run start pulse (IDLE only)
//   abort_i          : end run early (at handshake while a command is valid)
//   seed_i           : address seed; instr/blen use seed_i[14:0] / ~seed_i[14:0]
//   num_cmds_i       : commands per run
//   cmd_valid_o/cmd_ready_i/cmd_instr_o/cmd_addr_o/cmd_bl_o : command port
//   busy_o, done_o   : run in progress, one-cycle end-of-run pulse
//   cmd_cnt_o        : commands accepted in current/last run
// Optional macro TRAFFIC_SCHED_STALL_CNT_EN adds stall_cnt_o (valid & !ready cycles).
module traffic_cmd_sched
    import traffic_sched_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 29,
    parameter int unsigned           DWIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = ADDR_WIDTH'('h2000),
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = ADDR_WIDTH'('h1FFF),
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [31:0]           seed_i,
    input  logic [CNT_WIDTH-1:0]  num_cmds_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_instr_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [BL_W-1:0]       cmd_bl_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  cmd_cnt_o
`ifdef TRAFFIC_SCHED_STALL_CNT_EN
   ,output logic [31:0]           stall_cnt_o
`endif
);

    localparam int unsigned           ALIGN_BITS = $clog2(DWIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    sched_state_e state_q, state_d;
    logic                  valid_q, valid_d;
    logic [2:0]            instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BL_W-1:0]       bl_q, bl_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  max_q, max_d;

    logic                   lfsr_load;
    logic                   lfsr_step;
    logic                   fields_load;
    logic [ADDR_LFSR_W-1:0] addr_next;
    logic [AUX_LFSR_W-1:0]  instr_next;
    logic [AUX_LFSR_W-1:0]  blen_next;
    logic                   unused_lfsr_bits;

    logic                  hs_c;
    logic                  last_c;
    logic [CNT_WIDTH-1:0]  cnt_sat_c;
    logic [ADDR_WIDTH-1:0] addr_gen_c;

    sched_lfsr #(.WIDTH(ADDR_LFSR_W), .TAPS(ADDR_LFSR_TAPS)) u_lfsr_addr (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (lfsr_load),
        .seed_i   (seed_i),
        .step_i   (lfsr_step),
        .next_c_o (addr_next)
    );

    sched_lfsr #(.WIDTH(AUX_LFSR_W), .TAPS(AUX_LFSR_TAPS)) u_lfsr_instr (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (lfsr_load),
        .seed_i   (seed_i[AUX_LFSR_W-1:0]),
        .step_i   (lfsr_step),
        .next_c_o (instr_next)
    );

    sched_lfsr #(.WIDTH(AUX_LFSR_W), .TAPS(AUX_LFSR_TAPS)) u_lfsr_blen (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (lfsr_load),
        .seed_i   (~seed_i[AUX_LFSR_W-1:0]),
        .step_i   (lfsr_step),
        .next_c_o (blen_next)
    );

    // Only a few LFSR bits form command fields; the rest just feed the sequence.
    assign unused_lfsr_bits = ^{addr_next, instr_next, blen_next};

    assign hs_c       = valid_q & cmd_ready_i;
    assign last_c     = (({1'b0, cnt_q} + (CNT_WIDTH+1)'(1)) == {1'b0, max_q});
    assign cnt_sat_c  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    // Fields are formed from the post-step LFSR value, so sum wraps at ADDR_WIDTH.
    assign addr_gen_c = (ADDR_BASE + (addr_next[ADDR_WIDTH-1:0] & ADDR_MASK)) & ALIGN_MASK;

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        max_d       = max_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        fields_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    state_d = ST_SEED;
                    busy_d  = 1'b1;
                end
            end
            ST_SEED: begin
                lfsr_load = 1'b1;
                max_d     = num_cmds_i;
                cnt_d     = '0;
                if (abort_i || (num_cmds_i == '0)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    lfsr_step   = 1'b1;
                    fields_load = 1'b1;
                    valid_d     = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Valid is only dropped after a handshake, even under abort.
                if (hs_c) begin
                    cnt_d = cnt_sat_c;
                    if (last_c || abort_i) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        lfsr_step   = 1'b1;
                        fields_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Command field capture.
    always_comb begin
        instr_d = instr_q;
        addr_d  = addr_q;
        bl_d    = bl_q;
        if (fields_load) begin
            instr_d = instr_next[0] ? CMD_RD : CMD_WR;
            addr_d  = addr_gen_c;
            bl_d    = blen_from_lfsr(blen_next[BL_W-1:0]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
            bl_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            bl_q    <= bl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_instr_o = instr_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_bl_o    = bl_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cmd_cnt_o   = cnt_q;

`ifdef TRAFFIC_SCHED_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of presented-but-not-accepted cycles, cleared per run.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_SEED) begin
            stall_d = '0;
        end else if (valid_q && !cmd_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_traffic_cmd_sched.sv
// Randomised self-checking bench for traffic_cmd_sched against a
// behavioural command-stream and cycle model.
module tb_traffic_cmd_sched;

    typedef struct packed {
        logic [2:0]  instr;
        logic [28:0] addr;
        logic [5:0]  bl;
    } cmd_t;

    logic        clk_i;
    logic        rst_n_i;
    logic        start_i;
    logic        abort_i;
    logic [31:0] seed_i;
    logic [15:0] num_cmds_i;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [2:0]  cmd_instr_o;
    logic [28:0] cmd_addr_o;
    logic [5:0]  cmd_bl_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] cmd_cnt_o;
`ifdef TRAFFIC_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    cmd_t ref_q[$];

    traffic_cmd_sched dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .seed_i      (seed_i),
        .num_cmds_i  (num_cmds_i),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_instr_o (cmd_instr_o),
        .cmd_addr_o  (cmd_addr_o),
        .cmd_bl_o    (cmd_bl_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cmd_cnt_o   (cmd_cnt_o)
`ifdef TRAFFIC_SCHED_STALL_CNT_EN
       ,.stall_cnt_o (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Galois step: shift right, xor taps in when the bit shifted out is 1.
    function automatic longint unsigned prbs_step(input longint unsigned s, input longint unsigned taps);
        return (s / 2) ^ ((s % 2 == 1) ? taps : 0);
    endfunction

    // Expected command stream for a seed: one LFSR step before each command.
    task automatic build_model(input logic [31:0] seed, input int n);
        longint unsigned a, i, b, x;
        cmd_t c;
        exp_q.delete();
        a = seed;
        i = seed % 32768;
        b = (~seed) % 32768;
        if (a == 0) a = 1;
        if (i == 0) i = 1;
        if (b == 0) b = 1;
        for (int k = 0; k < n; k++) begin
            a = prbs_step(a, 64'h8020_0003);
            i = prbs_step(i, 64'h6000);
            b = prbs_step(b, 64'h6000);
            x = ((64'h2000 + (a % 8192)) % (64'd1 << 29)) / 4 * 4;
            c.addr  = 29'(x);
            c.instr = (i % 2 == 1) ? 3'b001 : 3'b000;
            c.bl    = (b % 64 == 0) ? 6'd1 : 6'(b % 64);
            exp_q.push_back(c);
        end
    endtask

    // rdy_mode: 0 ready tied high, 1 ready every third cycle, 2 random.
    task automatic do_run(input logic [31:0] seed, input int n, input int rdy_mode,
                          input int abort_at, input int rst_at, input int extra_start_at);
        int  acc, stalls, done_exp;
        bit  active, rdy, ended;
        cmd_t cur;
        build_model(seed, n);
        obs_q.delete();
        @(negedge clk_i);
        seed_i      = seed;
        num_cmds_i  = 16'(n);
        start_i     = 1'b1;
        abort_i     = 1'b0;
        cmd_ready_i = 1'b0;
        acc      = 0;
        stalls   = 0;
        ended    = 1'b0;
        done_exp = -1;
        if (n == 0 || abort_at <= 1) done_exp = 2;
        else if (abort_at == 2)      done_exp = 3;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk_i);
            start_i = (cyc == extra_start_at);
            abort_i = (cyc >= abort_at);
            if (cyc == rst_at) begin
                rst_n_i = 1'b0;
                #1;
                chk_eq("rst_mid_valid", 64'(cmd_valid_o), 64'd0);
                chk_eq("rst_mid_busy", 64'(busy_o), 64'd0);
                chk_eq("rst_mid_cnt", 64'(cmd_cnt_o), 64'd0);
                repeat (2) begin
                    @(negedge clk_i);
                    chk_eq("rst_mid_nodone", 64'(done_o), 64'd0);
                end
                rst_n_i = 1'b1;
                start_i = 1'b0;
                abort_i = 1'b0;
                return;
            end
            active = (done_exp < 0) && (cyc >= 3);
            chk_eq("valid", 64'(cmd_valid_o), 64'(active));
            chk_eq("done", 64'(done_o), 64'(cyc == done_exp));
            chk_eq("busy", 64'(busy_o), 64'((done_exp < 0) || (cyc < done_exp)));
            if (cyc >= 2) chk_eq("cmd_cnt", 64'(cmd_cnt_o), 64'(acc));
            cur = {cmd_instr_o, cmd_addr_o, cmd_bl_o};
            if (active) begin
                chk_eq("cmd_fields", 64'(cur), 64'(exp_q[acc]));
                chk_eq("addr_range", 64'((cmd_addr_o >= 29'h2000) && (cmd_addr_o <= 29'h3FFF)), 64'd1);
                chk_eq("addr_align", 64'(cmd_addr_o[1:0]), 64'd0);
            end
`ifdef TRAFFIC_SCHED_STALL_CNT_EN
            if (cyc == done_exp) chk_eq("stall_cnt", 64'(stall_cnt_o), 64'(stalls));
`endif
            if (done_exp >= 0 && cyc == done_exp + 1) begin
                ended = 1'b1;
                break;
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            cmd_ready_i = rdy;
            if (active) begin
                if (rdy) begin
                    obs_q.push_back(cur);
                    acc++;
                    if (acc == n || abort_i) done_exp = cyc + 1;
                end else begin
                    stalls++;
                end
            end
        end
        chk_eq("run_timeout", 64'(ended), 64'd1);
        start_i = 1'b0;
        abort_i = 1'b0;
        cmd_ready_i = 1'b0;
    endtask

    initial begin
        bit varied;
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        seed_i      = '0;
        num_cmds_i  = '0;
        cmd_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_eq("reset_valid", 64'(cmd_valid_o), 64'd0);
        chk_eq("reset_busy", 64'(busy_o), 64'd0);
        chk_eq("reset_done", 64'(done_o), 64'd0);
        chk_eq("reset_cnt", 64'(cmd_cnt_o), 64'd0);
        chk_eq("reset_fields", 64'({cmd_instr_o, cmd_addr_o, cmd_bl_o}), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Basic four-command run, ready tied high.
        do_run(32'h1, 4, 0, 100000, -1, -1);
        chk_eq("basic_count", 64'(obs_q.size()), 64'd4);

        // Zero-length run.
        do_run(32'hDEAD_BEEF, 0, 0, 100000, -1, -1);

        // Stalled run must present the identical stream; spurious start ignored.
        do_run(32'h1234_5678, 8, 0, 100000, -1, -1);
        ref_q = obs_q;
        do_run(32'h1234_5678, 8, 1, 100000, -1, 7);
        chk_eq("stall_len", 64'(obs_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++) chk_eq("stall_seq", 64'(obs_q[i]), 64'(ref_q[i]));

        // Abort while stalled in ISSUE, and in SEED / GEN.
        do_run(32'h1234_5678, 8, 1, 5, -1, 4);
        chk_eq("abort_count", 64'(obs_q.size()), 64'd2);
        do_run(32'h0BAD_F00D, 5, 0, 1, -1, -1);
        do_run(32'h0BAD_F00D, 5, 0, 2, -1, -1);

        // Zero seed still yields a varying address stream.
        do_run(32'h0, 40, 0, 100000, -1, -1);
        varied = 1'b0;
        for (int i = 1; i < obs_q.size(); i++) if (obs_q[i].addr != obs_q[0].addr) varied = 1'b1;
        chk_eq("seed0_varies", 64'(varied), 64'd1);

        // Reset mid-ISSUE, then a normal run.
        do_run(32'hCAFE_0001, 8, 1, 100000, 5, -1);
        do_run(32'hCAFE_0001, 6, 2, 100000, -1, -1);

        // Randomised runs.
        for (int r = 0; r < 12; r++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 100000;
            do_run($urandom, int'($urandom_range(1, 20)), 2, ab, -1, -1);
        end

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
